// File: rtl/ftl_arb_pkg.sv
// FTL shared-resource arbitrator: shared types and constants.
// Used by the requester-side client and its bench.
package ftl_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_REL   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int ARB_GUARD_CYC = 5;
  localparam int ARB_NCH       = 6;

endpackage

// File: rtl/arbiter_client.sv
// Requester-side agent for one arbitrator channel:
// request, burst of address beats, release, drain.
module arbiter_client
  import ftl_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              request,
  input  logic              permit,
  // release pulse; "release" itself is a reserved word
  output logic              rel,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ready,
  output logic              done,
  output logic              err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              rdy_n, req_n, rel_n;
  logic              bv_n, done_n, err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      bus_addr  <= '0;
      cmd_ready <= 1'b1;
      request   <= 1'b0;
      rel       <= 1'b0;
      bus_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      base_q    <= base_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      bus_addr  <= addr_n;
      cmd_ready <= rdy_n;
      request   <= req_n;
      rel       <= rel_n;
      bus_valid <= bv_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    addr_n  = bus_addr;
    req_n   = request;
    bv_n    = bus_valid;
    rel_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            base_n  = cmd_addr;
            len_n   = cmd_len;
            cnt_n   = '0;
            req_n   = 1'b1;
            state_n = ST_REQ;
          end else begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (permit) begin
          req_n   = 1'b0;
          bv_n    = 1'b1;
          addr_n  = base_q;
          state_n = ST_XFER;
        end
      end
      // permit is not consulted here: a started beat always completes
      ST_XFER: begin
        if (bus_valid && bus_ready) begin
          cnt_n  = cnt_q + LEN_W'(1);
          addr_n = bus_addr + ADDR_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            bv_n    = 1'b0;
            rel_n   = 1'b1;
            cnt_n   = '0;
            state_n = ST_REL;
          end
        end
      end
      ST_REL: begin
        state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!permit) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        bv_n    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
    rdy_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_arbiter_client.sv
// Six clients around a behavioural arbitrator;
// directed bursts, contention, wrap and reset.
module tb_arbiter_client;
  import ftl_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  cmd_valid = '0;
  logic [5:0]  bus_ready = '0;
  logic [5:0]  cmd_ready, request, permit, rel;
  logic [5:0]  bus_valid, done, err;
  logic [31:0] cmd_addr [ARB_NCH];
  logic [7:0]  cmd_len  [ARB_NCH];
  logic [31:0] bus_addr [ARB_NCH];

  for (genvar g = 0; g < ARB_NCH; g++) begin : g_cli
    arbiter_client #(.ADDR_W(32), .LEN_W(8)) u_cli (
      .clk       (clk),
      .reset     (rst_n),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_addr  (cmd_addr[g]),
      .cmd_len   (cmd_len[g]),
      .request   (request[g]),
      .permit    (permit[g]),
      .rel       (rel[g]),
      .bus_valid (bus_valid[g]),
      .bus_addr  (bus_addr[g]),
      .bus_ready (bus_ready[g]),
      .done      (done[g]),
      .err       (err[g])
    );
  end

  // fixed-priority arbitrator with guard cycles after each release
  int   guard;
  int   cur;
  logic busy;

  function automatic int pick(input logic [5:0] r);
    for (int i = 0; i < 6; i++)
      if (r[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      permit <= '0;
      busy   <= 1'b0;
      guard  <= 0;
      cur    <= 0;
    end else if (busy) begin
      if (rel[cur]) begin
        permit <= '0;
        busy   <= 1'b0;
        guard  <= ARB_GUARD_CYC;
      end
    end else if (guard > 0) begin
      guard <= guard - 1;
    end else if (request != '0) begin
      permit[pick(request)] <= 1'b1;
      cur  <= pick(request);
      busy <= 1'b1;
    end
  end

  // bus / arbitration monitor
  int   cyc = 0;
  int   overlap = 0;
  int   gap_err = 0;
  int   last_rel = -1;
  int   rel_cnt [6] = '{default: 0};
  int   beat_cnt [6] = '{default: 0};
  int   grant_q [$];
  logic [5:0] permit_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(bus_valid) > 1) overlap++;
    for (int i = 0; i < 6; i++) begin
      if (permit[i] && !permit_prev[i]) begin
        grant_q.push_back(i);
        if (last_rel >= 0 && cyc - last_rel < ARB_GUARD_CYC)
          gap_err++;
      end
      if (rel[i]) begin
        rel_cnt[i]++;
        last_rel = cyc;
      end
      if (bus_valid[i] && bus_ready[i]) beat_cnt[i]++;
    end
    permit_prev = permit;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  logic [31:0] beats [$];
  logic [31:0] exp_q [$];
  int   nrel, rel_at, first_b, last_b, done_at, stall_err;
  logic got_done, got_err, req_seen, rdy_at_done;

  task automatic issue(input int ch,
                       input logic [31:0] a,
                       input logic [7:0] l);
    cmd_addr[ch]  = a;
    cmd_len[ch]   = l;
    cmd_valid[ch] = 1'b1;
  endtask

  task automatic watch(input int ch, input bit tgl,
                       input int maxcyc);
    logic        pv, pacc;
    logic [31:0] pa;
    beats.delete();
    nrel = 0; rel_at = -1; first_b = -1; last_b = -1;
    done_at = -1; stall_err = 0;
    got_done = 0; got_err = 0; req_seen = 0;
    rdy_at_done = 0;
    pv = 0; pacc = 0; pa = '0;
    for (int c = 1; c <= maxcyc; c++) begin
      @(posedge clk); #1;
      cmd_valid[ch] = 1'b0;
      if (tgl) bus_ready[ch] = ~bus_ready[ch];
      if (request[ch]) req_seen = 1;
      if (rel[ch]) begin
        nrel++;
        if (rel_at < 0) rel_at = beats.size();
      end
      if (pv && !pacc &&
          (!bus_valid[ch] || bus_addr[ch] !== pa))
        stall_err++;
      pv   = bus_valid[ch];
      pa   = bus_addr[ch];
      pacc = bus_valid[ch] && bus_ready[ch];
      if (pacc) begin
        beats.push_back(bus_addr[ch]);
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      if (done[ch]) begin
        got_done = 1;
        got_err  = err[ch];
        rdy_at_done = cmd_ready[ch];
        done_at  = c;
        break;
      end
    end
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_nbeats"}, beats.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_beat%0d", tag, i),
          (i < beats.size()) ? beats[i] : 'x, exp_q[i]);
  endtask

  initial begin
    int          g0;
    int          rsnap [6];
    int          bsnap [6];
    logic [5:0]  dseen, derr;
    logic        found;

    for (int i = 0; i < 6; i++) begin
      cmd_addr[i] = '0;
      cmd_len[i]  = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_ctl%0d", i),
          {cmd_ready[i], request[i], rel[i],
           bus_valid[i], done[i], err[i]}, 6'b100000);
      chk($sformatf("rst_addr%0d", i), bus_addr[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single burst
    bus_ready[0] = 1'b1;
    issue(0, 32'h100, 8'd4);
    watch(0, 0, 100);
    exp_q = {32'h100, 32'h101, 32'h102, 32'h103};
    check_beats("single");
    chk("single_span", last_b - first_b, 3);
    chk("single_req", req_seen, 1);
    chk("single_nrel", nrel, 1);
    chk("single_done", got_done, 1);
    chk("single_err", got_err, 0);
    chk("single_rdy", rdy_at_done, 1);

    // back-pressure, issued in the cycle done is high
    issue(0, 32'h40, 8'd3);
    watch(0, 1, 200);
    exp_q = {32'h40, 32'h41, 32'h42};
    check_beats("bp");
    chk("bp_stall", stall_err, 0);
    chk("bp_nrel", nrel, 1);
    chk("bp_rel_after", rel_at, 3);
    chk("bp_done", got_done, 1);
    chk("bp_err", got_err, 0);

    // null command
    issue(4, 32'h55, 8'd0);
    watch(4, 0, 10);
    chk("null_done_at", done_at, 1);
    chk("null_err", got_err, 1);
    chk("null_req", req_seen, 0);

    // address wrap
    bus_ready[1] = 1'b1;
    issue(1, 32'hFFFF_FFFE, 8'd4);
    watch(1, 0, 100);
    exp_q = {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    check_beats("wrap");
    chk("wrap_done", got_done, 1);
    chk("wrap_err", got_err, 0);

    // contention between 0, 2 and 5
    bus_ready = '1;
    g0 = grant_q.size();
    for (int i = 0; i < 6; i++) begin
      rsnap[i] = rel_cnt[i];
      bsnap[i] = beat_cnt[i];
    end
    issue(0, 32'h1000, 8'd2);
    issue(2, 32'h2000, 8'd2);
    issue(5, 32'h5000, 8'd2);
    dseen = '0;
    derr  = '0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      cmd_valid = '0;
      dseen |= done;
      derr  |= done & err;
      if (dseen[0] && dseen[2] && dseen[5]) break;
    end
    chk("cont_done", dseen, 6'b100101);
    chk("cont_err", derr, 6'b000000);
    chk("cont_ngrant", grant_q.size() - g0, 3);
    chk("cont_g0", (grant_q.size() > g0) ?
        grant_q[g0] : -1, 0);
    chk("cont_g1", (grant_q.size() > g0 + 1) ?
        grant_q[g0+1] : -1, 2);
    chk("cont_g2", (grant_q.size() > g0 + 2) ?
        grant_q[g0+2] : -1, 5);
    chk("cont_overlap", overlap, 0);
    chk("cont_gap", gap_err, 0);
    chk("cont_rel0", rel_cnt[0] - rsnap[0], 1);
    chk("cont_rel2", rel_cnt[2] - rsnap[2], 1);
    chk("cont_rel5", rel_cnt[5] - rsnap[5], 1);
    chk("cont_beat0", beat_cnt[0] - bsnap[0], 2);
    chk("cont_beat2", beat_cnt[2] - bsnap[2], 2);
    chk("cont_beat5", beat_cnt[5] - bsnap[5], 2);

    // reset after two of five beats
    issue(3, 32'h200, 8'd5);
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      cmd_valid[3] = 1'b0;
      if (bus_valid[3] && bus_addr[3] === 32'h202) begin
        found = 1;
        break;
      end
    end
    chk("mid_reached", found, 1);
    rsnap[3] = rel_cnt[3];
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_ctl",
        {cmd_ready[3], request[3], rel[3],
         bus_valid[3], done[3], err[3]}, 6'b100000);
    chk("mid_addr", bus_addr[3], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_norel", rel_cnt[3] - rsnap[3], 0);

    issue(3, 32'h300, 8'd2);
    watch(3, 0, 100);
    exp_q = {32'h300, 32'h301};
    check_beats("post");
    chk("post_nrel", nrel, 1);
    chk("post_done", got_done, 1);
    chk("post_err", got_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
